// File: rtl/qdec_pkg.sv
// Quadrature decoder shared definitions.
//  - PH_xx      : encoder phase constants, written as {A,B}
//  - step_t     : result of comparing two consecutive phases
//  - decode_step: classifies a phase transition as none / up / down / illegal
package qdec_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DN,
      STEP_ERR
   } step_t;

   // Forward rotation walks 00 -> 10 -> 11 -> 01 -> 00. Any single-bit change
   // that is not the forward successor must be the reverse one.
   function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
      step_t      s;
      logic [1:0] fwd;
      s = STEP_NONE;
      case (prev)
         PH_00:   fwd = PH_10;
         PH_10:   fwd = PH_11;
         PH_11:   fwd = PH_01;
         default: fwd = PH_00;
      endcase
      if (prev != cur) begin
         if ((prev ^ cur) == 2'b11) s = STEP_ERR;
         else if (cur == fwd)       s = STEP_UP;
         else                       s = STEP_DN;
      end
      return s;
   endfunction

endpackage

// File: rtl/qdec_filter.sv
// One encoder channel: metastability synchroniser followed by a glitch filter.
//  clk    in  system clock
//  rst_n  in  asynchronous reset, active low
//  din    in  raw asynchronous channel input
//  dout   out filtered level; changes only after FILT_LEN consecutive samples
//             disagree with the current filtered value
module qdec_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [3:0]             cnt_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         dout   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         // Any sample agreeing with the filtered value restarts the run, so a
         // pulse shorter than FILT_LEN samples never reaches the toggle.
         if (sync_out == dout) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            dout  <= ~dout;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 4'd1;
         end
      end
   end

endmodule

// File: rtl/qdec_counter.sv
// Quadrature decoder and signed position counter (x4 decoding).
//  clk_i      in  system clock
//  reset_n_i  in  asynchronous reset, active low
//  a_i, b_i   in  encoder channels, asynchronous
//  enable_i   in  1 = count, 0 = hold position (phase still tracked)
//  invert_i   in  1 = swap count direction
//  set_i      in  strobe: load set_val_i (wins over a same-cycle step)
//  set_val_i  in  value loaded by set_i
//  err_clr_i  in  strobe: clear err_o (a same-cycle new error wins)
//  pos_o      out position, wraps modulo 2^POS_WIDTH
//  step_o     out 1-cycle pulse per counted edge
//  dir_o      out direction of last counted edge, 1 = up
//  err_o      out sticky illegal-transition flag
module qdec_counter
   import qdec_pkg::*;
#(
   parameter int POS_WIDTH   = 32,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 a_i,
   input  logic                 b_i,
   input  logic                 enable_i,
   input  logic                 invert_i,
   input  logic                 set_i,
   input  logic [POS_WIDTH-1:0] set_val_i,
   input  logic                 err_clr_i,
   output logic [POS_WIDTH-1:0] pos_o,
   output logic                 step_o,
   output logic                 dir_o,
   output logic                 err_o
);

   localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

   logic       a_filt;
   logic       b_filt;
   logic [1:0] cur_ph;
   logic [1:0] prev_ph;
   logic       valid;
   step_t      step;
   logic       count_up;

   qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
      .clk   (clk_i),
      .rst_n (reset_n_i),
      .din   (a_i),
      .dout  (a_filt)
   );

   qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
      .clk   (clk_i),
      .rst_n (reset_n_i),
      .din   (b_i),
      .dout  (b_filt)
   );

   assign cur_ph = {a_filt, b_filt};

   // Until one phase has been captured there is no reference to compare with.
   always_comb begin
      step = STEP_NONE;
      if (valid) step = decode_step(prev_ph, cur_ph);
   end

   assign count_up = (step == STEP_UP) ^ invert_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         prev_ph <= PH_00;
         valid   <= 1'b0;
         pos_o   <= '0;
         step_o  <= 1'b0;
         dir_o   <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         // Phase is tracked even while disabled so re-enabling cannot see a
         // stale reference and produce a phantom count.
         prev_ph <= cur_ph;
         valid   <= 1'b1;
         step_o  <= 1'b0;

         if (step == STEP_ERR)  err_o <= 1'b1;
         else if (err_clr_i)    err_o <= 1'b0;

         if (set_i) begin
            pos_o <= set_val_i;
         end else if (enable_i && (step == STEP_UP || step == STEP_DN)) begin
            pos_o  <= count_up ? pos_o + POS_ONE : pos_o - POS_ONE;
            step_o <= 1'b1;
            dir_o  <= count_up;
         end
      end
   end

endmodule

// File: tb/tb_qdec_counter.sv
module tb_qdec_counter;

   localparam int W    = 32;
   localparam int HOLD = 25;

   // ---------------- clock / reset / DUT ----------------
   logic         clk_i     = 1'b0;
   logic         reset_n_i = 1'b0;
   logic         a_i       = 1'b0;
   logic         b_i       = 1'b0;
   logic         enable_i  = 1'b1;
   logic         invert_i  = 1'b0;
   logic         set_i     = 1'b0;
   logic [W-1:0] set_val_i = '0;
   logic         err_clr_i = 1'b0;
   logic [W-1:0] pos_o;
   logic         step_o;
   logic         dir_o;
   logic         err_o;

   always #5 clk_i = ~clk_i;

   qdec_counter #(.POS_WIDTH(W), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .enable_i  (enable_i),
      .invert_i  (invert_i),
      .set_i     (set_i),
      .set_val_i (set_val_i),
      .err_clr_i (err_clr_i),
      .pos_o     (pos_o),
      .step_o    (step_o),
      .dir_o     (dir_o),
      .err_o     (err_o)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int           vectors     = 0;
   int           miscompares = 0;
   int           step_cnt    = 0;
   int           exp_steps   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_pos = '0;
   logic         m_dir = 1'b0;
   int           pidx  = 0;
   logic [1:0]   ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   // step_o pulses counted away from the active edge
   always @(negedge clk_i) if (step_o === 1'b1) step_cnt++;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed pos %h expected scoreboard entry, queue empty", tag, pos_o);
      end else begin
         e = exp_q.pop_front();
         check(tag, pos_o, e);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_step(input string tag, input bit fwd);
      bit up;
      if (enable_i) begin
         up    = fwd ^ invert_i;
         m_pos = up ? m_pos + 1'b1 : m_pos - 1'b1;
         m_dir = up;
         exp_steps++;
      end
      exp_q.push_back(m_pos);
      pidx = fwd ? (pidx + 1) % 4 : (pidx + 3) % 4;
      @(negedge clk_i);
      {a_i, b_i} = ph_tab[pidx];
      repeat (HOLD) @(negedge clk_i);
      sb_check(tag);
      check({tag, "_steps"}, W'(step_cnt), W'(exp_steps));
      check({tag, "_dir"}, W'(dir_o), W'(m_dir));
   endtask

   task automatic set_pos(input logic [W-1:0] val);
      @(negedge clk_i);
      set_i     = 1'b1;
      set_val_i = val;
      @(negedge clk_i);
      set_i = 1'b0;
      m_pos = val;
      exp_q.push_back(m_pos);
      sb_check("set_load");
   endtask

   task automatic pulse_a(input int n);
      @(negedge clk_i);
      a_i = ~a_i;
      repeat (n) @(negedge clk_i);
      a_i = ~a_i;
      repeat (HOLD) @(negedge clk_i);
   endtask

   task automatic clear_err();
      @(negedge clk_i);
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
      check("err_clr", W'(err_o), W'(1'b0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(negedge clk_i);
      check("rst_pos", pos_o, '0);
      check("rst_step", W'(step_o), '0);
      check("rst_dir", W'(dir_o), '0);
      check("rst_err", W'(err_o), '0);
      reset_n_i = 1'b1;
      repeat (10) @(negedge clk_i);

      // 8 forward, 3 reverse
      for (int i = 0; i < 8; i++) do_step("fwd", 1'b1);
      check("fwd_err", W'(err_o), '0);
      for (int i = 0; i < 3; i++) do_step("rev", 1'b0);

      // inverted direction: forward rotation counts down
      @(negedge clk_i);
      invert_i = 1'b1;
      for (int i = 0; i < 3; i++) do_step("inv", 1'b1);
      @(negedge clk_i);
      invert_i = 1'b0;

      // load 0 then underflow
      set_pos('0);
      do_step("underflow", 1'b0);

      // set coincident with a counted edge: load wins, no pulse
      pidx = (pidx + 1) % 4;
      @(negedge clk_i);
      {a_i, b_i} = ph_tab[pidx];
      repeat (6) @(negedge clk_i);
      set_i     = 1'b1;
      set_val_i = 32'h1234_5678;
      @(negedge clk_i);
      set_i = 1'b0;
      m_pos = 32'h1234_5678;
      exp_q.push_back(m_pos);
      repeat (HOLD) @(negedge clk_i);
      sb_check("set_vs_step");
      check("set_vs_step_steps", W'(step_cnt), W'(exp_steps));

      // signed overflow wrap
      set_pos(32'h7FFF_FFFF);
      do_step("wrap", 1'b1);

      // glitch filter: 3-cycle pulse rejected, 4-cycle pulse passes twice
      pulse_a(3);
      exp_q.push_back(m_pos);
      sb_check("glitch3_pos");
      check("glitch3_steps", W'(step_cnt), W'(exp_steps));
      pulse_a(4);
      exp_steps += 2;
      exp_q.push_back(m_pos);
      sb_check("glitch4_pos");
      check("glitch4_steps", W'(step_cnt), W'(exp_steps));
      check("glitch4_dir", W'(dir_o), W'(1'b1));

      // illegal double-edge 10 -> 01
      pidx = 3;
      @(negedge clk_i);
      {a_i, b_i} = ph_tab[pidx];
      repeat (HOLD) @(negedge clk_i);
      check("illegal_err", W'(err_o), W'(1'b1));
      exp_q.push_back(m_pos);
      sb_check("illegal_pos");
      check("illegal_steps", W'(step_cnt), W'(exp_steps));
      clear_err();

      // illegal 01 -> 10 coincident with err_clr: set wins
      pidx = 1;
      @(negedge clk_i);
      {a_i, b_i} = ph_tab[pidx];
      repeat (6) @(negedge clk_i);
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
      check("err_set_wins", W'(err_o), W'(1'b1));
      repeat (HOLD) @(negedge clk_i);
      clear_err();

      // reach 5 then reset mid-rotation
      set_pos(32'd2);
      for (int i = 0; i < 3; i++) do_step("pre_rst", 1'b1);
      @(negedge clk_i);
      reset_n_i = 1'b0;
      #1;
      check("midrst_pos", pos_o, '0);
      check("midrst_step", W'(step_o), '0);
      check("midrst_dir", W'(dir_o), '0);
      check("midrst_err", W'(err_o), '0);
      repeat (3) @(negedge clk_i);
      reset_n_i = 1'b1;
      m_pos = '0;
      m_dir = 1'b0;
      repeat (HOLD) @(negedge clk_i);
      exp_q.push_back(m_pos);
      sb_check("post_rst_idle");
      do_step("post_rst", 1'b1);

      // disabled: phase tracked, position holds, no spurious count on re-enable
      @(negedge clk_i);
      enable_i = 1'b0;
      for (int i = 0; i < 4; i++) do_step("disabled", 1'b1);
      @(negedge clk_i);
      enable_i = 1'b1;
      repeat (HOLD) @(negedge clk_i);
      exp_q.push_back(m_pos);
      sb_check("reenable_idle");
      check("reenable_steps", W'(step_cnt), W'(exp_steps));
      do_step("reenable", 1'b1);

      // ---------------- final report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
